regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port among NREQ write-back producers (ALU pipe, load/store unit, mul/div unit) using round-robin arbitration.
- Registers the winning write into a one-stage output that drives the register file we/waddr/wdata.
- Keeps a 32-entry pending-write scoreboard that issue logic queries for RAW hazards.
- Sits between the execute-side producers and the register file, next to the issue stage.

---
 rtl/regfile_wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port among NREQ write-back
//   producers using round-robin arbitration. The winning write is registered
//   into a one-stage output that drives the register file. A 32-entry
//   pending-write scoreboard is also kept here so that issue logic can check
//   for RAW hazards.
//
//   Optional feature macro: REGFILE_WB_ARB_STAT_EN
//     defined   : stall_cnt counts the cycles in which a valid requester was
//                 denied. It saturates at all-ones and is cleared by rst only.
//     undefined : stall_cnt is tied to zero.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid [NREQ]         per-requester write pending
//   req_waddr [5*NREQ]       per-requester destination register (slice i = 5i+4:5i)
//   req_wdata [32*NREQ]      per-requester write data (slice i = 32i+31:32i)
//   req_ready [NREQ]         one-hot combinational grant
//   rf_we/rf_waddr/rf_wdata  registered register file write port
//   alloc_valid, alloc_addr  issue-stage destination allocation (sets busy)
//   flush                    clears the scoreboard, except same-cycle allocations
//   qaddr1/2, qbusy1/2       hazard queries
//   busy_vec                 raw scoreboard bits
//   stall_cnt                denied-cycle statistics counter
module regfile_wb_arbiter #(
    parameter int NREQ    = 3,
    parameter int RR_INIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [5*NREQ-1:0]  req_waddr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [31:0]        rf_wdata,
    input  logic               alloc_valid,
    input  logic [4:0]         alloc_addr,
    input  logic               flush,
    input  logic [4:0]         qaddr1,
    input  logic [4:0]         qaddr2,
    output logic               qbusy1,
    output logic               qbusy2,
    output logic [31:0]        busy_vec,
    output logic [31:0]        stall_cnt
);

    localparam int            PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] RR_RST  = PW'(RR_INIT);
    localparam logic [PW-1:0] RR_LAST = PW'(NREQ - 1);

    logic [4:0]      waddr_arr [NREQ];
    logic [31:0]     wdata_arr [NREQ];

    logic [PW-1:0]   rr_p0;
    logic [NREQ-1:0] grant_p0;
    logic            gnt_vld_p0;
    logic [PW-1:0]   gnt_idx_p0;
    logic [4:0]      gnt_waddr_p0;
    logic [31:0]     gnt_wdata_p0;
    logic [31:0]     busy_nxt;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign waddr_arr[i] = req_waddr[5*i +: 5];
        assign wdata_arr[i] = req_wdata[32*i +: 32];
    end

    // ---- stage p0: combinational round-robin arbitration ----
    always_comb begin
        int            pos;
        logic [PW-1:0] idx;
        grant_p0     = '0;
        gnt_vld_p0   = 1'b0;
        gnt_idx_p0   = '0;
        gnt_waddr_p0 = '0;
        gnt_wdata_p0 = '0;
        pos          = 0;
        idx          = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Walk from rr upward, wrapping at NREQ without a modulo operator.
            pos = int'(rr_p0) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            idx = PW'(pos);
            if (!rst && !gnt_vld_p0 && req_valid[idx]) begin
                gnt_vld_p0    = 1'b1;
                gnt_idx_p0    = idx;
                grant_p0[idx] = 1'b1;
                gnt_waddr_p0  = waddr_arr[idx];
                gnt_wdata_p0  = wdata_arr[idx];
            end
        end
    end

    assign req_ready = grant_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_p0 <= RR_RST;
        end else if (gnt_vld_p0) begin
            rr_p0 <= (gnt_idx_p0 == RR_LAST) ? '0 : gnt_idx_p0 + 1'b1;
        end
    end

    // ---- stage p1: registered register file write ----
    // A write to r0 is consumed here but never raises rf_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (gnt_vld_p0) begin
            rf_we    <= (gnt_waddr_p0 != 5'd0);
            rf_waddr <= gnt_waddr_p0;
            rf_wdata <= gnt_wdata_p0;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Scoreboard: retire clears, flush clears, and a new allocation set is
    // applied last so it wins over both.
    always_comb begin
        busy_nxt = busy_vec;
        if (rf_we) begin
            busy_nxt[rf_waddr] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        if (alloc_valid) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

    // The retiring write counts as not busy: the register file forwards it.
    assign qbusy1 = busy_vec[qaddr1] && !(rf_we && (rf_waddr == qaddr1));
    assign qbusy2 = busy_vec[qaddr2] && !(rf_we && (rf_waddr == qaddr2));

`ifdef REGFILE_WB_ARB_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (((req_valid & ~grant_p0) != '0) && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, a statistics
// sequence, then randomized traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_waddr;
    logic [32*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [31:0]        rf_wdata;
    logic               alloc_valid;
    logic [4:0]         alloc_addr;
    logic               flush;
    logic [4:0]         qaddr1;
    logic [4:0]         qaddr2;
    logic               qbusy1;
    logic               qbusy2;
    logic [31:0]        busy_vec;
    logic [31:0]        stall_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(NREQ), .RR_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .flush(flush),
        .qaddr1(qaddr1), .qaddr2(qaddr2), .qbusy1(qbusy1), .qbusy2(qbusy2),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_rr;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_busy;
    logic [31:0] m_stall;
    int          last_g = -1;

    function automatic int model_grant();
        if (rst) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if ((req_valid & NREQ'(1 << i)) != 0) return i;
        end
        return -1;
    endfunction

    task automatic check_model();
        int          g;
        logic [2:0]  er;
        logic        eq1, eq2;
        logic [31:0] es;
        g   = model_grant();
        er  = (g >= 0) ? 3'(1 << g) : 3'b000;
        eq1 = m_busy[qaddr1] && !(m_we && m_waddr == qaddr1);
        eq2 = m_busy[qaddr2] && !(m_we && m_waddr == qaddr2);
`ifdef REGFILE_WB_ARB_STAT_EN
        es = m_stall;
`else
        es = 32'h0;
`endif
        chk("model ready",    32'(req_ready), 32'(er));
        chk("model rf_we",    32'(rf_we),     32'(m_we));
        chk("model rf_waddr", 32'(rf_waddr),  32'(m_waddr));
        chk("model rf_wdata", rf_wdata,       m_wdata);
        chk("model busy_vec", busy_vec,       m_busy);
        chk("model qbusy1",   32'(qbusy1),    32'(eq1));
        chk("model qbusy2",   32'(qbusy2),    32'(eq2));
        chk("model stall",    stall_cnt,      es);
    endtask

    task automatic model_step();
        int          g;
        logic [31:0] setm, clrm;
        logic [4:0]  wa;
        logic        denied;
        g = model_grant();
        last_g = g;
        if (rst) begin
            m_rr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
            m_busy = '0; m_stall = '0;
            return;
        end
        denied = (req_valid != 0) && !(g >= 0 && req_valid == 3'(1 << g));
        if (denied && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        setm = (alloc_valid && alloc_addr != 0) ? (32'h1 << alloc_addr) : 32'h0;
        clrm = m_we ? (32'h1 << m_waddr) : 32'h0;
        m_busy = flush ? setm : ((m_busy & ~clrm) | setm);
        if (g >= 0) begin
            m_rr    = (g + 1) % NREQ;
            wa      = 5'(req_waddr >> (5 * g));
            m_we    = (wa != 0);
            m_waddr = wa;
            m_wdata = 32'(req_wdata >> (32 * g));
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic [2:0]  v;
        logic [14:0] wa;
        logic [95:0] wd;
        logic        av;
        logic [4:0]  aa;
        logic        fl;
        logic [4:0]  q1;
        logic [2:0]  e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
        logic        e_q1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [2:0] v, logic [14:0] wa, logic [95:0] wd,
                                logic av, logic [4:0] aa, logic fl, logic [4:0] q1,
                                logic [2:0] er, logic ew, logic [4:0] ewa, logic [31:0] ewd,
                                logic [31:0] eb, logic eq1);
        vec_t t;
        t.r = r; t.v = v; t.wa = wa; t.wd = wd; t.av = av; t.aa = aa; t.fl = fl; t.q1 = q1;
        t.e_rdy = er; t.e_we = ew; t.e_wa = ewa; t.e_wd = ewd; t.e_busy = eb; t.e_q1 = eq1;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  a;
        logic [31:0] es;
        rst = 1'b1; req_valid = '0; req_waddr = '0; req_wdata = '0;
        alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0; qaddr1 = '0; qaddr2 = '0;
        repeat (2) @(posedge clk);
        model_step();
        #1;

        // r, v, wa{2,1,0}, wd{2,1,0}, av, aa, fl, q1 | rdy, we, waddr, wdata, busy, q1
        tbl.push_back(mk(1'b1, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd5}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0));
        // round robin 0,1,2 with back-to-back writes
        tbl.push_back(mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b110, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b010, 1'b1, 5'd1, 32'hA1, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b100, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b100, 1'b1, 5'd2, 32'hB2, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b1, 5'd3, 32'hC3, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd3, 32'hC3, 32'h0, 1'b0));
        // r0 write from requester 1
        tbl.push_back(mk(1'b0, 3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h55, 32'h0}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b010, 1'b0, 5'd3, 32'hC3, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h55, 32'h0, 1'b0));
        // scoreboard set, query, retire
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b1, 5'd7, 1'b0, 5'd7, 3'b000, 1'b0, 5'd0, 32'h55, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77}, 1'b0, 5'd0, 1'b0, 5'd7, 3'b001, 1'b0, 5'd0, 32'h55, 32'h80, 1'b1));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd7, 3'b000, 1'b1, 5'd7, 32'h77, 32'h80, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd7, 3'b000, 1'b0, 5'd7, 32'h77, 32'h0, 1'b0));
        // same-cycle alloc and retire of r7: set wins
        tbl.push_back(mk(1'b0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h99, 32'h0}, 1'b1, 5'd7, 1'b0, 5'd0, 3'b010, 1'b0, 5'd7, 32'h77, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b1, 5'd7, 1'b0, 5'd7, 3'b000, 1'b1, 5'd7, 32'h99, 32'h80, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd7, 3'b000, 1'b0, 5'd7, 32'h99, 32'h80, 1'b1));
        // flush with a concurrent allocation of r4
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b1, 5'd3, 1'b0, 5'd0, 3'b000, 1'b0, 5'd7, 32'h99, 32'h80, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b1, 5'd9, 1'b0, 5'd0, 3'b000, 1'b0, 5'd7, 32'h99, 32'h88, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b1, 5'd4, 1'b1, 5'd0, 3'b000, 1'b0, 5'd7, 32'h99, 32'h288, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd7, 32'h99, 32'h10, 1'b0));
        // reset with a write in flight, then rr back at RR_INIT
        tbl.push_back(mk(1'b0, 3'b001, {5'd0, 5'd0, 5'd12}, {32'h0, 32'h0, 32'h1234}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 1'b0, 5'd7, 32'h99, 32'h10, 1'b0));
        tbl.push_back(mk(1'b1, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b1, 5'd12, 32'h1234, 32'h10, 1'b0));
        tbl.push_back(mk(1'b0, 3'b101, {5'd2, 5'd0, 5'd1}, {32'hBB, 32'h0, 32'hAA}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b100, {5'd2, 5'd0, 5'd1}, {32'hBB, 32'h0, 32'hAA}, 1'b0, 5'd0, 1'b0, 5'd0, 3'b100, 1'b1, 5'd1, 32'hAA, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b1, 5'd2, 32'hBB, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, 96'h0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd2, 32'hBB, 32'h0, 1'b0));

        foreach (tbl[i]) begin
            rst = tbl[i].r; req_valid = tbl[i].v; req_waddr = tbl[i].wa; req_wdata = tbl[i].wd;
            alloc_valid = tbl[i].av; alloc_addr = tbl[i].aa; flush = tbl[i].fl;
            qaddr1 = tbl[i].q1; qaddr2 = 5'd0;
            @(negedge clk);
            chk($sformatf("row%0d ready", i),    32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d rf_we", i),    32'(rf_we),     32'(tbl[i].e_we));
            chk($sformatf("row%0d rf_waddr", i), 32'(rf_waddr),  32'(tbl[i].e_wa));
            chk($sformatf("row%0d rf_wdata", i), rf_wdata,       tbl[i].e_wd);
            chk($sformatf("row%0d busy_vec", i), busy_vec,       tbl[i].e_busy);
            chk($sformatf("row%0d qbusy1", i),   32'(qbusy1),    32'(tbl[i].e_q1));
            check_model();
            @(posedge clk);
            model_step();
            #1;
        end

        // statistics: two requesters contend once, then drain
        rst = 1'b1; req_valid = '0; alloc_valid = 1'b0; flush = 1'b0;
        run_cycle();
        rst = 1'b0; req_valid = 3'b011; req_waddr = {5'd0, 5'd2, 5'd1}; req_wdata = {32'h0, 32'h22, 32'h11};
        run_cycle();
        req_valid = 3'b010;
        run_cycle();
        req_valid = 3'b000;
        run_cycle();
`ifdef REGFILE_WB_ARB_STAT_EN
        es = 32'd1;
`else
        es = 32'd0;
`endif
        @(negedge clk);
        chk("stat stall_cnt", stall_cnt, es);
        check_model();
        @(posedge clk);
        model_step();
        #1;

        // randomized traffic: requesters hold until granted
        for (int c = 0; c < 3000; c++) begin
            if (last_g >= 0) req_valid = req_valid & ~3'(1 << last_g);
            for (int i = 0; i < NREQ; i++) begin
                if ((req_valid & 3'(1 << i)) == 0 && ($urandom % 2) == 0) begin
                    a = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    req_waddr = (req_waddr & ~(15'h1F << (5 * i))) | (15'(a) << (5 * i));
                    req_wdata = (req_wdata & ~(96'hFFFF_FFFF << (32 * i))) | (96'($urandom) << (32 * i));
                    req_valid = req_valid | 3'(1 << i);
                end
            end
            alloc_valid = ($urandom % 3) == 0;
            alloc_addr  = 5'($urandom);
            flush       = ($urandom % 40) == 0;
            rst         = ($urandom % 200) == 0;
            qaddr1      = 5'($urandom);
            qaddr2      = ($urandom % 2 == 0) ? m_waddr : 5'($urandom);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
